// File: rtl/mc68030_bus_master_if.sv
// Client request/response and 68030 local-bus signals for mc68030_bus_master.
//   master : the bus initiator's view. It takes client requests and bus
//            responses in, and drives client responses and bus controls out.
//   slave  : the opposite view, for the client and the memory side.
// Signal summary:
//   REQ/REQ_A/REQ_RW/REQ_SIZ/REQ_BURST/REQ_WDATA  client request
//   REQ_ACK/RDATA/RVALID/RBEAT/DONE/ERR           client response
//   A/SIZ/RW30/AS30/DS30/CBREQ/D_OUT/D_OE         bus controls (strobes active low)
//   STERM/CBACK/D_IN                              bus responses (active low)
interface mc68030_bus_master_if;
    logic        REQ;
    logic [31:0] REQ_A;
    logic        REQ_RW;
    logic [1:0]  REQ_SIZ;
    logic        REQ_BURST;
    logic [31:0] REQ_WDATA;
    logic        REQ_ACK;
    logic [31:0] RDATA;
    logic        RVALID;
    logic [1:0]  RBEAT;
    logic        DONE;
    logic        ERR;
    logic [31:0] A;
    logic [1:0]  SIZ;
    logic        RW30;
    logic        AS30;
    logic        DS30;
    logic        CBREQ;
    logic [31:0] D_OUT;
    logic        D_OE;
    logic        STERM;
    logic        CBACK;
    logic [31:0] D_IN;

    modport master (
        input  REQ, REQ_A, REQ_RW, REQ_SIZ, REQ_BURST, REQ_WDATA,
               STERM, CBACK, D_IN,
        output REQ_ACK, RDATA, RVALID, RBEAT, DONE, ERR,
               A, SIZ, RW30, AS30, DS30, CBREQ, D_OUT, D_OE
    );

    modport slave (
        output REQ, REQ_A, REQ_RW, REQ_SIZ, REQ_BURST, REQ_WDATA,
               STERM, CBACK, D_IN,
        input  REQ_ACK, RDATA, RVALID, RBEAT, DONE, ERR,
               A, SIZ, RW30, AS30, DS30, CBREQ, D_OUT, D_OE
    );
endinterface

// File: rtl/mc68030_bus_master.sv
// Synchronous-termination bus initiator for the 68030-style local bus.
// It turns one client request into a single bus cycle, or into a 4-beat
// line burst when a read burst is requested and the slave answers with CBACK.
// Ports:
//   CLK    bus clock; every state change happens on the rising edge
//   RESET  synchronous, active-high reset
//   bus    mc68030_bus_master_if.master (client and bus signals)
// Parameters:
//   TIMEOUT   clocks of STERM high per beat before the cycle aborts with ERR
//   IDLE_GAP  minimum clocks spent in GAP between cycles (>=1)
module mc68030_bus_master #(
    parameter int TIMEOUT  = 64,
    parameter int IDLE_GAP = 1
) (
    input  logic CLK,
    input  logic RESET,
    mc68030_bus_master_if.master bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(IDLE_GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_BEAT, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   a_q, a_d;
    logic [1:0]    siz_q, siz_d;
    logic          rw_q, rw_d;
    logic          as_q, as_d;
    logic          ds_q, ds_d;
    logic          cbreq_q, cbreq_d;
    logic [31:0]   dout_q, dout_d;
    logic          doe_q, doe_d;
    logic          ack_q, ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic [1:0]    rbeat_q, rbeat_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    beat_q, beat_d;

    logic in_cycle;
    logic accept;
    logic tmo_hit;
    logic gap_last;
    logic burst_req;

    assign in_cycle  = (state_q == S_ASSERT) || (state_q == S_BEAT);
    assign accept    = in_cycle && !bus.STERM;
    // The counter holds the number of STERM-high edges already seen in this beat.
    assign tmo_hit   = in_cycle && bus.STERM && (tmo_q == TW'(TIMEOUT - 1));
    assign gap_last  = (gap_q == GW'(IDLE_GAP - 1));
    assign burst_req = bus.REQ_BURST && bus.REQ_RW;

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            siz_q    <= '0;
            rw_q     <= 1'b1;
            as_q     <= 1'b1;
            ds_q     <= 1'b1;
            cbreq_q  <= 1'b1;
            dout_q   <= '0;
            doe_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rbeat_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
            gap_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            siz_q    <= siz_d;
            rw_q     <= rw_d;
            as_q     <= as_d;
            ds_q     <= ds_d;
            cbreq_q  <= cbreq_d;
            dout_q   <= dout_d;
            doe_q    <= doe_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rbeat_q  <= rbeat_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            beat_q   <= beat_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.REQ) state_d = S_ASSERT;
            end
            S_ASSERT: begin
                // Burst continues only if CBREQ and CBACK are both low on the terminating edge.
                if (!bus.STERM)   state_d = (!cbreq_q && !bus.CBACK) ? S_BEAT : S_GAP;
                else if (tmo_hit) state_d = S_GAP;
            end
            S_BEAT: begin
                if (!bus.STERM) begin
                    if (beat_q == 2'd3) state_d = S_GAP;
                end else if (tmo_hit) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        a_d      = a_q;
        siz_d    = siz_q;
        rw_d     = rw_q;
        as_d     = as_q;
        ds_d     = ds_q;
        cbreq_d  = cbreq_q;
        dout_d   = dout_q;
        doe_d    = doe_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        rbeat_d  = rbeat_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        beat_d   = beat_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.REQ) begin
                    ack_d   = 1'b1;
                    a_d     = bus.REQ_A;
                    siz_d   = burst_req ? 2'b00 : bus.REQ_SIZ;
                    rw_d    = bus.REQ_RW;
                    as_d    = 1'b0;
                    ds_d    = 1'b0;
                    cbreq_d = !burst_req;
                    tmo_d   = '0;
                    beat_d  = '0;
                    if (!bus.REQ_RW) begin
                        dout_d = bus.REQ_WDATA;
                        doe_d  = 1'b1;
                    end
                end
            end
            S_ASSERT, S_BEAT: begin
                if (accept) begin
                    tmo_d = '0;
                    if (rw_q) begin
                        rvalid_d = 1'b1;
                        rbeat_d  = beat_q;
                        rdata_d  = bus.D_IN;
                    end
                    if (state_d == S_BEAT) begin
                        // Wrap within the 16-byte line.
                        a_d[3:2] = a_q[3:2] + 2'd1;
                        beat_d   = beat_q + 2'd1;
                        if (beat_q == 2'd2) cbreq_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (state_d == S_GAP) begin
                    as_d    = 1'b1;
                    ds_d    = 1'b1;
                    cbreq_d = 1'b1;
                    rw_d    = 1'b1;
                    doe_d   = 1'b0;
                    gap_d   = '0;
                    done_d  = accept;
                    err_d   = !accept;
                end
            end
            S_GAP: begin
                gap_d = gap_q + GW'(1);
            end
            default: ;
        endcase
    end

    assign bus.A       = a_q;
    assign bus.SIZ     = siz_q;
    assign bus.RW30    = rw_q;
    assign bus.AS30    = as_q;
    assign bus.DS30    = ds_q;
    assign bus.CBREQ   = cbreq_q;
    assign bus.D_OUT   = dout_q;
    assign bus.D_OE    = doe_q;
    assign bus.REQ_ACK = ack_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RBEAT   = rbeat_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_mc68030_bus_master.sv
// Scoreboard bench for mc68030_bus_master. The stimulus thread pushes the
// expected read beats and the DONE/ERR outcome for each request. A monitor
// pops and compares these whenever RVALID, DONE or ERR is seen. Bus-level
// timing is checked in the stimulus thread. The memory side answers with
// D_IN = A ^ 32'hC0DE0000, so every read beat reveals the address it came from.
module tb_mc68030_bus_master;

    logic CLK;
    logic RESET;
    mc68030_bus_master_if bus_if ();

    mc68030_bus_master #(.TIMEOUT(8), .IDLE_GAP(1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign bus_if.D_IN = bus_if.A ^ 32'hC0DE0000;

    typedef struct {
        int          kind;   // 0 read beat, 1 done, 2 err
        logic [1:0]  beat;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int sterm_delay = 1;
    bit sterm_never = 0;

    // Memory responder: STERM low once AS30 has been low for sterm_delay clocks.
    initial begin
        int as_cnt;
        as_cnt = 0;
        bus_if.STERM = 1'b1;
        forever begin
            @(negedge CLK);
            if (bus_if.AS30 == 1'b0) begin
                as_cnt++;
                bus_if.STERM = (sterm_never || as_cnt < sterm_delay) ? 1'b1 : 1'b0;
            end else begin
                as_cnt = 0;
                bus_if.STERM = 1'b1;
            end
        end
    end

    task automatic push(input int kind, input logic [1:0] beat, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.beat = beat;
        e.data = data;
        q.push_back(e);
    endtask

    function automatic void pop_check(input int kind, input logic [1:0] beat, input logic [31:0] data);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected event kind=%0d beat=%0d data=%h, nothing expected", kind, beat, data);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || (kind == 0 && (e.beat != beat || e.data != data))) begin
                errors++;
                $display("FAIL scoreboard: got kind=%0d beat=%0d data=%h, expected kind=%0d beat=%0d data=%h",
                         kind, beat, data, e.kind, e.beat, e.data);
            end
        end
    endfunction

    // Monitor
    initial begin
        forever begin
            @(negedge CLK);
            if (bus_if.RVALID) pop_check(0, bus_if.RBEAT, bus_if.RDATA);
            if (bus_if.DONE)   pop_check(1, 2'd0, 32'd0);
            if (bus_if.ERR)    pop_check(2, 2'd0, 32'd0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic rw, input logic [1:0] siz,
                         input logic burst, input logic [31:0] wdata, output bit got);
        got = 0;
        bus_if.REQ       = 1'b1;
        bus_if.REQ_A     = addr;
        bus_if.REQ_RW    = rw;
        bus_if.REQ_SIZ   = siz;
        bus_if.REQ_BURST = burst;
        bus_if.REQ_WDATA = wdata;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (bus_if.REQ_ACK) begin
                got = 1;
                break;
            end
        end
        bus_if.REQ = 1'b0;
        chk("req_ack", {31'd0, got}, 32'd1);
    endtask

    task automatic do_cycle(input logic [31:0] addr, input logic rw, input logic [1:0] siz,
                            input logic burst, input logic [31:0] wdata,
                            input int exp_as_low, input bit exp_err, input logic [31:0] exp_a_end);
        bit got;
        bit ended;
        int n_low;
        logic isburst;
        isburst = burst & rw;
        issue(addr, rw, siz, burst, wdata, got);
        if (!got) return;
        chk("as30_low_after_ack", {31'd0, bus_if.AS30}, 32'd0);
        chk("ds30_low_after_ack", {31'd0, bus_if.DS30}, 32'd0);
        chk("addr_after_ack", bus_if.A, addr);
        chk("rw30_after_ack", {31'd0, bus_if.RW30}, {31'd0, rw});
        chk("siz_after_ack", {30'd0, bus_if.SIZ}, isburst ? 32'd0 : {30'd0, siz});
        chk("cbreq_after_ack", {31'd0, bus_if.CBREQ}, {31'd0, ~isburst});
        chk("d_oe_after_ack", {31'd0, bus_if.D_OE}, {31'd0, ~rw});
        if (!rw) chk("d_out_after_ack", bus_if.D_OUT, wdata);
        n_low = 1;
        ended = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK); #1;
            if (bus_if.DONE || bus_if.ERR) begin
                ended = 1;
                break;
            end
            if (!bus_if.AS30) n_low++;
            if (!rw && !bus_if.AS30) chk("d_oe_during_write", {31'd0, bus_if.D_OE}, 32'd1);
            if (bus_if.RVALID && bus_if.RBEAT == 2'd2)
                chk("cbreq_high_beat3", {30'd0, bus_if.CBREQ, bus_if.AS30}, 32'd2);
        end
        chk("cycle_ended", {31'd0, ended}, 32'd1);
        if (!ended) return;
        chk("err_flag", {31'd0, bus_if.ERR}, {31'd0, exp_err});
        chk("done_flag", {31'd0, bus_if.DONE}, {31'd0, ~exp_err});
        chk("strobes_after_end", {28'd0, bus_if.AS30, bus_if.DS30, bus_if.CBREQ, bus_if.RW30}, 32'hF);
        chk("d_oe_after_end", {31'd0, bus_if.D_OE}, 32'd0);
        chk("as30_low_clocks", n_low, exp_as_low);
        chk("addr_at_end", bus_if.A, exp_a_end);
    endtask

    initial begin
        RESET            = 1'b1;
        bus_if.REQ       = 1'b0;
        bus_if.REQ_A     = '0;
        bus_if.REQ_RW    = 1'b1;
        bus_if.REQ_SIZ   = '0;
        bus_if.REQ_BURST = 1'b0;
        bus_if.REQ_WDATA = '0;
        bus_if.CBACK     = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_strobes", {28'd0, bus_if.AS30, bus_if.DS30, bus_if.CBREQ, bus_if.RW30}, 32'hF);
        chk("reset_a", bus_if.A, 32'd0);
        chk("reset_siz_doe", {29'd0, bus_if.SIZ, bus_if.D_OE}, 32'd0);
        chk("reset_d_out", bus_if.D_OUT, 32'd0);
        chk("reset_pulses", {28'd0, bus_if.REQ_ACK, bus_if.RVALID, bus_if.DONE, bus_if.ERR}, 32'd0);
        chk("reset_rdata", bus_if.RDATA, 32'd0);
        chk("reset_rbeat", {30'd0, bus_if.RBEAT}, 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Single long read, STERM two clocks after AS30
        sterm_delay = 2;
        push(0, 2'd0, 32'hC0CE0008);
        push(1, 2'd0, 32'd0);
        do_cycle(32'h00100008, 1'b1, 2'b00, 1'b0, 32'd0, 2, 1'b0, 32'h00100008);

        // Burst read with wrap: A[3:2] 11,00,01,10
        sterm_delay = 1;
        bus_if.CBACK = 1'b0;
        push(0, 2'd0, 32'hC0CE000C);
        push(0, 2'd1, 32'hC0CE0000);
        push(0, 2'd2, 32'hC0CE0004);
        push(0, 2'd3, 32'hC0CE0008);
        push(1, 2'd0, 32'd0);
        do_cycle(32'h0010000C, 1'b1, 2'b10, 1'b1, 32'd0, 4, 1'b0, 32'h00100008);

        // Burst requested but refused by the slave
        bus_if.CBACK = 1'b1;
        push(0, 2'd0, 32'hC0CE000C);
        push(1, 2'd0, 32'd0);
        do_cycle(32'h0010000C, 1'b1, 2'b00, 1'b1, 32'd0, 1, 1'b0, 32'h0010000C);

        // Byte write with REQ_BURST set: must not burst
        bus_if.CBACK = 1'b0;
        push(1, 2'd0, 32'd0);
        do_cycle(32'h00000003, 1'b0, 2'b01, 1'b1, 32'h000000A5, 1, 1'b0, 32'h00000003);
        bus_if.CBACK = 1'b1;

        // Word read with a slower slave
        sterm_delay = 3;
        push(0, 2'd0, 32'hC0DE2002);
        push(1, 2'd0, 32'd0);
        do_cycle(32'h00002002, 1'b1, 2'b10, 1'b0, 32'd0, 3, 1'b0, 32'h00002002);

        // Timeout: STERM never asserted, ERR after 8 clocks
        sterm_never = 1;
        push(2, 2'd0, 32'd0);
        do_cycle(32'h00000100, 1'b1, 2'b00, 1'b0, 32'd0, 8, 1'b1, 32'h00000100);
        sterm_never = 0;

        // Reset during beat 1 of a burst
        begin
            bit got;
            bit seen;
            sterm_delay = 1;
            bus_if.CBACK = 1'b0;
            push(0, 2'd0, 32'hC0FE0004);
            push(0, 2'd1, 32'hC0FE0008);
            issue(32'h00200004, 1'b1, 2'b00, 1'b1, 32'd0, got);
            seen = 0;
            for (int i = 0; i < 20 && got; i++) begin
                @(posedge CLK); #1;
                if (bus_if.RVALID && bus_if.RBEAT == 2'd1) begin
                    seen = 1;
                    break;
                end
            end
            chk("burst_beat1_seen", {31'd0, seen}, 32'd1);
            RESET = 1'b1;
            @(posedge CLK); #1;
            RESET = 1'b0;
            bus_if.CBACK = 1'b1;
            chk("midreset_strobes", {29'd0, bus_if.AS30, bus_if.DS30, bus_if.CBREQ}, 32'h7);
            chk("midreset_no_done_err", {30'd0, bus_if.DONE, bus_if.ERR}, 32'd0);
            chk("midreset_a", bus_if.A, 32'd0);
        end

        // New request after reset is accepted normally
        push(1, 2'd0, 32'd0);
        do_cycle(32'h00000010, 1'b0, 2'b00, 1'b0, 32'h12345678, 1, 1'b0, 32'h00000010);

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc68030_bus_master.md
Name: mc68030_bus_master

Overview:
- Synchronous-termination bus initiator for the 68030-style local bus. It drives address, SIZ, AS30, DS30, RW30 and CBREQ, and completes cycles on STERM with optional CBACK burst fills.
- It sits at the opposite end of the bus from the SDRAM controller.
- Used by on-board DMA/blitter logic, and as a synthesizable exerciser for the memory slave on the board.
- Converts a single-request client interface into one bus cycle, or a 4-beat line burst.

Parameters:
- TIMEOUT, 64, clocks from AS30 assertion with no STERM before the cycle is aborted with an error
- IDLE_GAP, 1, minimum clocks AS30 is held high between consecutive cycles (>=1)

Ports:
- CLK  in  1  bus clock; all state changes on the rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  1  client request; sampled only in IDLE
- REQ_A  in  32  client byte address
- REQ_RW  in  1  1=read, 0=write
- REQ_SIZ  in  2  00=long, 01=byte, 10=word, 11=3-byte
- REQ_BURST  in  1  request a line burst (reads only)
- REQ_WDATA  in  32  write data
- REQ_ACK  out  1  one-clock pulse when the request is latched
- RDATA  out  32  read data of the current beat
- RVALID  out  1  one-clock pulse per accepted read beat
- RBEAT  out  2  beat index (0..3) qualifying RVALID
- DONE  out  1  one-clock pulse when the bus cycle ends normally
- ERR  out  1  one-clock pulse when the cycle ends on timeout
- A  out  32  bus address
- SIZ  out  2  bus size
- RW30  out  1  bus read/write
- AS30  out  1  address strobe, active low
- DS30  out  1  data strobe, active low
- CBREQ  out  1  burst request, active low
- D_OUT  out  32  write data to bus
- D_OE  out  1  data output enable
- STERM  in  1  synchronous termination, active low
- CBACK  in  1  burst acknowledge, active low
- D_IN  in  32  read data from bus

Behaviour:
- Reset values (RESET high, and the clock after it):
  - AS30=DS30=CBREQ=RW30=1; D_OE=0; A=0; SIZ=00; D_OUT=0.
  - REQ_ACK=RVALID=DONE=ERR=0; RDATA=0; RBEAT=0; state=IDLE.
- RESET asserted mid-cycle: strobes negate on the next edge, with no DONE or ERR pulse.
- States: IDLE, ASSERT, BEAT, GAP.
- IDLE:
  - With REQ=1 and gap counter expired: latch the request and pulse REQ_ACK.
  - Drive A, SIZ and RW30 from the latched request; AS30=0, DS30=0.
  - CBREQ=0 only if REQ_BURST=1 and REQ_RW=1.
  - Write: D_OUT=REQ_WDATA, D_OE=1.
  - Next state ASSERT.
- Latency: request accepted at edge N; strobes are low after edge N. The earliest termination is STERM low sampled at edge N+1.
- ASSERT:
  - Sample STERM each edge; increment the timeout counter.
  - STERM=0: beat 0 completes. For a read, RDATA=D_IN, RVALID=1, RBEAT=0.
  - Burst continues only if CBREQ=0 AND CBACK=0 are sampled on that same edge. Then next state is BEAT and A[3:2] increments mod 4 (wrap within line; A[31:4] and A[1:0] unchanged).
  - Otherwise end the cycle.
  - Counter reaches TIMEOUT with STERM still high: end the cycle with ERR.
- BEAT:
  - Each STERM=0 edge accepts one further beat (RBEAT=1,2,3) and advances A[3:2].
  - CBREQ negates (1) on the edge accepting beat 2, so it is high during beat 3.
  - Beat 3 accepted: end the cycle.
  - Timeout counter restarts per beat; timeout yields ERR.
- End of cycle:
  - On the next edge, AS30=DS30=CBREQ=1, D_OE=0, RW30=1.
  - Pulse DONE (or ERR, never both).
  - Enter GAP for IDLE_GAP clocks, then IDLE.
- Writes never burst. SIZ is forced to 00 for bursts.
- STERM sampled while in IDLE or GAP is ignored.
- CBACK going high mid-burst is ignored; the burst always completes 4 beats.
- REQ held high across cycles: each cycle needs its own REQ_ACK. There are no back-to-back cycles without a GAP.

Test Plan:
- Single long read at 0x00100008, STERM low 2 clocks after AS30: REQ_ACK pulse; AS30 low for 2 clocks; one RVALID with RBEAT=0, RDATA=D_IN; DONE; AS30 high for >=1 clock.
- Burst read at 0x0010000C with CBACK=0 and STERM low every clock:
  - RVALID x4 with RBEAT 0..3.
  - A[3:2] sequence 11,00,01,10.
  - CBREQ high during the 4th beat; single DONE.
- Burst request with CBACK=1: only one beat; DONE; A[3:2] unchanged.
- Byte write 0xA5 at 0x00000003, SIZ=01: RW30=0, D_OE=1 and D_OUT valid while AS30 low; CBREQ stays high; DONE; D_OE=0 after.
- STERM never asserted with TIMEOUT=8: ERR pulse exactly 8 clocks after AS30 falls, no DONE, strobes negated.
- RESET pulsed during beat 1 of a burst: next edge AS30=DS30=CBREQ=1, state IDLE, no DONE/ERR; a new REQ is then accepted normally.
